// File: rtl/conv_spad_ctrl.sv
// Sequencing controller for one PE row-convolution pass: filter load, ifmap
// window fill, K-tap compute per output, psum handshake and window slide.
module conv_spad_ctrl #(
   parameter int FILT_SIZE  = 3,
   parameter int CNT_WIDTH  = 8,
   parameter int ADDR_WIDTH = $clog2(FILT_SIZE)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start,
   input  logic                  reuse_filt,
   input  logic [CNT_WIDTH-1:0]  num_out,
   input  logic                  filt_valid,
   output logic                  filt_ready,
   input  logic                  ifmap_valid,
   output logic                  ifmap_ready,
   output logic                  filt_wen,
   output logic [ADDR_WIDTH-1:0] filt_waddr,
   output logic [ADDR_WIDTH-1:0] filt_raddr,
   output logic                  if_wen,
   output logic [ADDR_WIDTH-1:0] if_waddr,
   output logic [ADDR_WIDTH-1:0] if_raddr,
   output logic                  mac_en,
   output logic                  acc_clr,
   output logic                  psum_valid,
   input  logic                  psum_ready,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [2:0] {IDLE, LOAD_F, FILL, COMPUTE, OUT, SHIFT, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(FILT_SIZE - 1);
   localparam logic [ADDR_WIDTH:0]   K_EXT = (ADDR_WIDTH+1)'(FILT_SIZE);

   state_t state, next_state;
   logic [ADDR_WIDTH-1:0] load_cnt, tap, wb;
   logic [CNT_WIDTH-1:0]  out_cnt, num_q;
   logic [ADDR_WIDTH:0]   rd_sum, rd_wrap;
   logic                  last_load, last_tap, last_out;

   assign last_load = (load_cnt == LAST);
   assign last_tap  = (tap == LAST);
   assign last_out  = (out_cnt == (num_q - CNT_WIDTH'(1)));

   // Circular window read: (wb + tap) mod K without a divider.
   assign rd_sum  = {1'b0, wb} + {1'b0, tap};
   assign rd_wrap = rd_sum - K_EXT;

   assign filt_wen = filt_valid & filt_ready;
   assign if_wen   = ifmap_valid & ifmap_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      filt_ready  = 1'b0;
      ifmap_ready = 1'b0;
      filt_waddr  = '0;
      filt_raddr  = '0;
      if_waddr    = '0;
      if_raddr    = '0;
      mac_en      = 1'b0;
      acc_clr     = 1'b0;
      psum_valid  = 1'b0;
      busy        = 1'b1;
      done        = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (num_out == '0)   next_state = DONE;
               else if (reuse_filt) next_state = FILL;
               else                 next_state = LOAD_F;
            end
         end
         LOAD_F: begin
            filt_ready = 1'b1;
            filt_waddr = load_cnt;
            if (filt_valid && last_load) next_state = FILL;
         end
         FILL: begin
            ifmap_ready = 1'b1;
            if_waddr    = load_cnt;
            if (ifmap_valid && last_load) next_state = COMPUTE;
         end
         COMPUTE: begin
            mac_en     = 1'b1;
            acc_clr    = (tap == '0);
            filt_raddr = tap;
            if_raddr   = (rd_sum >= K_EXT) ? rd_wrap[ADDR_WIDTH-1:0] : rd_sum[ADDR_WIDTH-1:0];
            if (last_tap) next_state = OUT;
         end
         OUT: begin
            psum_valid = 1'b1;
            if (psum_ready) next_state = last_out ? DONE : SHIFT;
         end
         SHIFT: begin
            ifmap_ready = 1'b1;
            if_waddr    = wb;
            if (ifmap_valid) next_state = COMPUTE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Counters advance only on accepted handshakes, so stalls simply hold them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         load_cnt <= '0;
         tap      <= '0;
         wb       <= '0;
         out_cnt  <= '0;
         num_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  num_q    <= num_out;
                  load_cnt <= '0;
                  tap      <= '0;
                  wb       <= '0;
                  out_cnt  <= '0;
               end
            end
            LOAD_F: begin
               if (filt_valid) load_cnt <= last_load ? '0 : load_cnt + ADDR_WIDTH'(1);
            end
            FILL: begin
               if (ifmap_valid) begin
                  load_cnt <= last_load ? '0 : load_cnt + ADDR_WIDTH'(1);
                  if (last_load) wb <= '0;
               end
            end
            COMPUTE: begin
               tap <= last_tap ? '0 : tap + ADDR_WIDTH'(1);
            end
            OUT: begin
               if (psum_ready) out_cnt <= out_cnt + CNT_WIDTH'(1);
            end
            SHIFT: begin
               if (ifmap_valid) wb <= (wb == LAST) ? '0 : wb + ADDR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_spad_ctrl.sv
// Self-checking bench for conv_spad_ctrl: a phase-level model predicts every
// output per cycle from the stimulus tables, plus literal latency/count pins.
module tb_conv_spad_ctrl;

   localparam int K    = 3;
   localparam int CW   = 8;
   localparam int AW   = 2;
   localparam int MAXC = 64;

   typedef struct packed {
      logic          filt_ready;
      logic          ifmap_ready;
      logic          filt_wen;
      logic          if_wen;
      logic [AW-1:0] filt_waddr;
      logic [AW-1:0] filt_raddr;
      logic [AW-1:0] if_waddr;
      logic [AW-1:0] if_raddr;
      logic          mac_en;
      logic          acc_clr;
      logic          psum_valid;
      logic          busy;
      logic          done;
   } vec_t;

   logic          clk = 1'b0;
   logic          rstn;
   logic          start;
   logic          reuse_filt;
   logic [CW-1:0] num_out;
   logic          filt_valid;
   logic          filt_ready;
   logic          ifmap_valid;
   logic          ifmap_ready;
   logic          filt_wen;
   logic [AW-1:0] filt_waddr;
   logic [AW-1:0] filt_raddr;
   logic          if_wen;
   logic [AW-1:0] if_waddr;
   logic [AW-1:0] if_raddr;
   logic          mac_en;
   logic          acc_clr;
   logic          psum_valid;
   logic          psum_ready;
   logic          busy;
   logic          done;

   conv_spad_ctrl #(.FILT_SIZE(K), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstn(rstn), .start(start), .reuse_filt(reuse_filt), .num_out(num_out),
      .filt_valid(filt_valid), .filt_ready(filt_ready),
      .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
      .filt_wen(filt_wen), .filt_waddr(filt_waddr), .filt_raddr(filt_raddr),
      .if_wen(if_wen), .if_waddr(if_waddr), .if_raddr(if_raddr),
      .mac_en(mac_en), .acc_clr(acc_clr),
      .psum_valid(psum_valid), .psum_ready(psum_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   bit    fv [MAXC];
   bit    iv [MAXC];
   bit    pr [MAXC];
   bit    st [MAXC];
   vec_t  exp_vec [MAXC];
   vec_t  act_v;

   int    pass_cnt = 0;
   int    total_cnt = 0;
   int    cyc = 0;
   bit    active = 1'b0;
   string label = "";
   int    done_seen, n_fw, n_iw, n_ps, n_pv, n_fr, n_clr;
   int    raddr_q[$];
   int    wadr_q[$];

   function automatic vec_t dut_vec();
      vec_t v;
      v.filt_ready  = filt_ready;
      v.ifmap_ready = ifmap_ready;
      v.filt_wen    = filt_wen;
      v.if_wen      = if_wen;
      v.filt_waddr  = filt_waddr;
      v.filt_raddr  = filt_raddr;
      v.if_waddr    = if_waddr;
      v.if_raddr    = if_raddr;
      v.mac_en      = mac_en;
      v.acc_clr     = acc_clr;
      v.psum_valid  = psum_valid;
      v.busy        = busy;
      v.done        = done;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual === expected) pass_cnt++;
      else $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
   endtask

   task automatic reset_stim();
      for (int i = 0; i < MAXC; i++) begin
         fv[i] = 1'b1;
         iv[i] = 1'b1;
         pr[i] = 1'b1;
         st[i] = 1'b0;
      end
   endtask

   // Pass model: walk the phases (load, fill, per-output taps + psum + slide)
   // against the stimulus tables; window base for output o is o mod K.
   task automatic build_model(input bit reuse, input int n, output int done_c);
      int   c;
      vec_t v;
      for (int i = 0; i < MAXC; i++) exp_vec[i] = '0;
      c = 1;
      if (n != 0) begin
         if (!reuse) begin
            for (int i = 0; i < K; i++) begin
               while (!fv[c] && c < MAXC - 2) begin
                  v = '0; v.busy = 1'b1; v.filt_ready = 1'b1; v.filt_waddr = AW'(i);
                  exp_vec[c] = v; c++;
               end
               v = '0; v.busy = 1'b1; v.filt_ready = 1'b1; v.filt_wen = 1'b1; v.filt_waddr = AW'(i);
               exp_vec[c] = v; c++;
            end
         end
         for (int i = 0; i < K; i++) begin
            while (!iv[c] && c < MAXC - 2) begin
               v = '0; v.busy = 1'b1; v.ifmap_ready = 1'b1; v.if_waddr = AW'(i);
               exp_vec[c] = v; c++;
            end
            v = '0; v.busy = 1'b1; v.ifmap_ready = 1'b1; v.if_wen = 1'b1; v.if_waddr = AW'(i);
            exp_vec[c] = v; c++;
         end
         for (int o = 0; o < n; o++) begin
            for (int t = 0; t < K; t++) begin
               v = '0; v.busy = 1'b1; v.mac_en = 1'b1; v.acc_clr = (t == 0);
               v.filt_raddr = AW'(t); v.if_raddr = AW'((o + t) % K);
               exp_vec[c] = v; c++;
            end
            while (!pr[c] && c < MAXC - 2) begin
               v = '0; v.busy = 1'b1; v.psum_valid = 1'b1;
               exp_vec[c] = v; c++;
            end
            v = '0; v.busy = 1'b1; v.psum_valid = 1'b1;
            exp_vec[c] = v; c++;
            if (o < n - 1) begin
               while (!iv[c] && c < MAXC - 2) begin
                  v = '0; v.busy = 1'b1; v.ifmap_ready = 1'b1; v.if_waddr = AW'(o % K);
                  exp_vec[c] = v; c++;
               end
               v = '0; v.busy = 1'b1; v.ifmap_ready = 1'b1; v.if_wen = 1'b1; v.if_waddr = AW'(o % K);
               exp_vec[c] = v; c++;
            end
         end
      end
      v = '0; v.busy = 1'b1; v.done = 1'b1;
      exp_vec[c] = v;
      done_c = c;
   endtask

   // Runs one pass from IDLE; abort_at > 0 stops driving at that cycle.
   task automatic apply_stimulus(input string name, input bit reuse, input int n, input int abort_at);
      int done_c;
      build_model(reuse, n, done_c);
      label = name;
      done_seen = 0; n_fw = 0; n_iw = 0; n_ps = 0; n_pv = 0; n_fr = 0; n_clr = 0;
      raddr_q.delete();
      wadr_q.delete();
      reuse_filt = reuse;
      num_out    = CW'(n);
      start      = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 1; c <= done_c + 2; c++) begin
         cyc         = c;
         filt_valid  = fv[c];
         ifmap_valid = iv[c];
         psum_ready  = pr[c];
         start       = st[c];
         if (c == abort_at) begin
            active = 1'b0;
            break;
         end
         active = 1'b1;
         @(posedge clk); #1;
      end
      active = 1'b0;
      start  = 1'b0;
   endtask

   always @(negedge clk) begin
      if (active) begin
         act_v = dut_vec();
         check_output($sformatf("%s_cycle%0d", label, cyc), 32'(act_v), 32'(exp_vec[cyc]));
         if (done && done_seen == 0) done_seen = cyc;
         if (filt_wen) n_fw++;
         if (if_wen) begin
            n_iw++;
            wadr_q.push_back(int'(if_waddr));
         end
         if (psum_valid && psum_ready) n_ps++;
         if (psum_valid) n_pv++;
         if (filt_ready) n_fr++;
         if (acc_clr) n_clr++;
         if (mac_en) raddr_q.push_back(int'(if_raddr));
      end
   end

   initial begin
      int seq[12];
      int wseq[4];
      rstn = 1'b0; start = 1'b0; reuse_filt = 1'b0; num_out = '0;
      filt_valid = 1'b0; ifmap_valid = 1'b0; psum_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_output("reset_state", 32'(dut_vec()), 32'h0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      reset_stim();
      apply_stimulus("basic", 1'b0, 4, 0);
      check_output("basic_done_cycle", 32'(done_seen), 32'd26);
      check_output("basic_psum_accepts", 32'(n_ps), 32'd4);
      check_output("basic_filt_writes", 32'(n_fw), 32'd3);
      check_output("basic_if_writes", 32'(n_iw), 32'd6);
      check_output("basic_acc_clr", 32'(n_clr), 32'd4);
      seq = '{0, 1, 2, 1, 2, 0, 2, 0, 1, 0, 1, 2};
      check_output("basic_raddr_len", 32'(raddr_q.size()), 32'd12);
      for (int i = 0; i < 12; i++)
         check_output($sformatf("basic_if_raddr%0d", i),
                      (i < raddr_q.size()) ? 32'(raddr_q[i]) : 32'hFFFF, 32'(seq[i]));

      reset_stim();
      for (int c = 2; c <= 6; c++) st[c] = 1'b1;
      apply_stimulus("reuse", 1'b1, 2, 0);
      check_output("reuse_done_cycle", 32'(done_seen), 32'd13);
      check_output("reuse_filt_ready", 32'(n_fr), 32'd0);
      check_output("reuse_psum_accepts", 32'(n_ps), 32'd2);

      reset_stim();
      for (int c = 10; c <= 14; c++) pr[c] = 1'b0;
      apply_stimulus("backpressure", 1'b0, 4, 0);
      check_output("bp_done_cycle", 32'(done_seen), 32'd31);
      check_output("bp_psum_valid_cycles", 32'(n_pv), 32'd9);
      check_output("bp_psum_accepts", 32'(n_ps), 32'd4);

      reset_stim();
      for (int c = 0; c < MAXC; c++) iv[c] = (c % 2 == 1);
      apply_stimulus("starved", 1'b1, 2, 0);
      check_output("starved_done_cycle", 32'(done_seen), 32'd16);
      check_output("starved_if_writes", 32'(n_iw), 32'd4);
      wseq = '{0, 1, 2, 0};
      for (int i = 0; i < 4; i++)
         check_output($sformatf("starved_if_waddr%0d", i),
                      (i < wadr_q.size()) ? 32'(wadr_q[i]) : 32'hFFFF, 32'(wseq[i]));

      reset_stim();
      apply_stimulus("zero_out", 1'b0, 0, 0);
      check_output("zero_done_cycle", 32'(done_seen), 32'd1);
      check_output("zero_handshakes", 32'(n_fw + n_iw + n_ps), 32'd0);

      reset_stim();
      apply_stimulus("abort", 1'b0, 2, 8);
      #2 rstn = 1'b0;
      #1 check_output("async_reset_outputs", 32'(dut_vec()), 32'h0);
      check_output("abort_no_done", 32'(done_seen), 32'd0);
      @(posedge clk); #1;
      check_output("reset_hold_idle", {30'd0, busy, done}, 32'd0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      check_output("post_reset_idle", {30'd0, busy, done}, 32'd0);

      reset_stim();
      apply_stimulus("after_reset", 1'b0, 2, 0);
      check_output("after_reset_done_cycle", 32'(done_seen), 32'd16);
      check_output("after_reset_psum_accepts", 32'(n_ps), 32'd2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/conv_spad_ctrl.md
# conv_spad_ctrl

Sequencing controller for one PE row-convolution pass. It drives the control side of two register-array scratchpads: a filter scratchpad holding FILT_SIZE weights and an ifmap scratchpad used as a FILT_SIZE-deep circular sliding window. It also drives the MAC/accumulator enables and a psum output handshake. Data buses run directly from the input streams to the scratchpad `din`; this block generates only the write enables, addresses and read addresses.

## Interface
- FILT_SIZE, 3: filter taps K. Must be at least 2. The ifmap scratchpad also holds K entries.
- CNT_WIDTH, 8: width of the output-count field.
- ADDR_WIDTH, $clog2(FILT_SIZE): scratchpad address width.
- clk  in  1  clock. All state changes on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass. Sampled only in IDLE.
- reuse_filt  in  1  latched with start. 1 skips filter load.
- num_out  in  CNT_WIDTH  number of psums for this pass. Latched with start.
- filt_valid / filt_ready  in / out  1  filter word handshake.
- ifmap_valid / ifmap_ready  in / out  1  ifmap word handshake.
- filt_wen  out  1  equals filt_valid & filt_ready.
- filt_waddr  out  ADDR_WIDTH  filter write address.
- filt_raddr  out  ADDR_WIDTH  filter read address (tap index).
- if_wen  out  1  equals ifmap_valid & ifmap_ready.
- if_waddr / if_raddr  out  ADDR_WIDTH  ifmap write and read addresses.
- mac_en  out  1  accumulator adds filt×ifmap this cycle.
- acc_clr  out  1  accumulator loads the product instead of adding it (tap 0).
- psum_valid / psum_ready  out / in  1  psum output handshake.
- busy  out  1  high when state is not IDLE.
- done  out  1  one-cycle pulse at pass end.

## Operation
- States: IDLE, LOAD_F, FILL, COMPUTE, OUT, SHIFT, DONE.
- IDLE:
  - start=1 and num_out=0 → DONE.
  - start=1 and reuse_filt=1 → FILL.
  - start=1 otherwise → LOAD_F.
  - start is ignored in every other state.
- LOAD_F:
  - filt_ready=1.
  - Each accepted word is written at filt_waddr = load counter (0..K-1).
  - After K accepts → FILL.
- FILL:
  - ifmap_ready=1.
  - Accepted words are written at if_waddr = 0..K-1.
  - After K accepts: window base wb=0, → COMPUTE.
- COMPUTE:
  - Tap counter t runs 0..K-1, one tap per cycle, with no stall.
  - filt_raddr=t and if_raddr=(wb+t) mod K.
  - mac_en=1 every cycle; acc_clr=1 only when t=0.
  - After t=K-1 → OUT.
- OUT:
  - psum_valid=1 and held until psum_ready.
  - On accept, the output counter increments.
  - If this was the last output → DONE, else → SHIFT.
- SHIFT:
  - ifmap_ready=1.
  - The accepted word is written at if_waddr=wb, overwriting the oldest entry.
  - wb ← (wb+1) mod K, then → COMPUTE.
  - There is no SHIFT after the last output.
- DONE: done=1 for one cycle → IDLE.
- Address wrap: every address counter wraps K-1→0. For non-power-of-two K, the values K..2^ADDR_WIDTH-1 are never driven.
- Filter contents persist across passes, which is what makes reuse_filt=1 valid. The controller does not check whether the filter is valid.
- Handshake signals (filt_valid, ifmap_valid, psum_ready) arriving in states that do not use them have no effect. The matching write enables stay 0.

## Timing
- Reset (asynchronous assert): state=IDLE and all counters and wb = 0. Every output is 0: ready, wen, mac_en, acc_clr, psum_valid, busy, done. All addresses are 0.
- Reset mid-pass aborts immediately, with no done pulse. The first pass after reset must use reuse_filt=0.
- All outputs are decoded from registered state and counters. The only exceptions are filt_wen and if_wen, which also include the valid input combinationally.
- Scratchpad reads are combinational, so the accumulator samples the tap in the same cycle that mac_en is high. psum data is valid at the accumulator output throughout OUT.
- Latency from the start edge to the done cycle, with all valids and psum_ready held high: (reuse_filt ? K : 2K) + num_out·(K+1) + (num_out−1) + 1.
- Each deasserted valid or ready cycle adds exactly one cycle in LOAD_F, FILL, OUT or SHIFT.

## Test plan
- Basic pass: K=3, num_out=4, reuse_filt=0, all valids and psum_ready high.
  - done at cycle 26.
  - Exactly 4 psum accepts, 3 filter writes, 6 ifmap writes.
  - if_raddr sequences per output: 0,1,2 / 1,2,0 / 2,0,1 / 0,1,2.
  - acc_clr on the first tap of each output only.
- Reuse filter: second pass with reuse_filt=1, num_out=2.
  - filt_ready never asserts.
  - done at cycle 3+8+1+1=13.
- Backpressure: psum_ready low for 5 cycles in the first OUT.
  - psum_valid held high for 6 cycles.
  - No mac_en and no state advance meanwhile.
  - Total latency +5.
- Starved inputs: ifmap_valid toggles 1,0,1,0 during FILL and SHIFT.
  - Writes occur only on valid cycles, at the correct addresses.
  - Latency increases by the count of low-valid cycles.
- Edge cases:
  - num_out=0 → done in the cycle after start, no handshakes.
  - start pulsed while busy → ignored.
- Async reset: assert rstn low mid-COMPUTE, between clock edges.
  - All outputs 0 before the next edge.
  - No done pulse.
  - A following pass runs normally.
